// File: rtl/fp_op_driver.sv
// Batch initiator for the single-precision unit stb/ack protocol: streams operand
// pairs from an operand RAM through one arithmetic unit and writes results back.
module fp_op_driver #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   count,
  input  logic [ADDR_W-1:0] op_base,
  input  logic [ADDR_W-1:0] res_base,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   nan_count,
  output logic              op_rd_en,
  output logic [ADDR_W-1:0] op_addr,
  input  logic [63:0]       op_rd_data,
  output logic              res_wr_en,
  output logic [ADDR_W-1:0] res_addr,
  output logic [31:0]       res_wr_data,
  output logic [31:0]       output_a,
  output logic              output_a_stb,
  input  logic              output_a_ack,
  output logic [31:0]       output_b,
  output logic              output_b_stb,
  input  logic              output_b_ack,
  input  logic [31:0]       input_z,
  input  logic              input_z_stb,
  output logic              input_z_ack
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] FETCH  = 3'd1;
  localparam logic [2:0] LOAD   = 3'd2;
  localparam logic [2:0] SEND   = 3'd3;
  localparam logic [2:0] WAIT_Z = 3'd4;
  localparam logic [2:0] WRITE  = 3'd5;
  localparam logic [2:0] DONE   = 3'd6;

  localparam logic [ADDR_W:0]   CNT_ZERO = {(ADDR_W+1){1'b0}};
  localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   NAN_MAX  = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};

  function automatic logic is_nan(input logic [31:0] w);
    return (w[30:23] == 8'hFF) && (w[22:0] != 23'h000000);
  endfunction

  logic [2:0]        state_r;
  logic [ADDR_W:0]   count_r;
  logic [ADDR_W:0]   index_r;
  logic [ADDR_W-1:0] op_base_r;
  logic [ADDR_W-1:0] res_base_r;

  logic              a_clear_s;
  logic              b_clear_s;
  logic              last_s;
  logic [ADDR_W:0]   next_index_s;

  // An operand is finished once its stb is already low or it transfers on this edge.
  assign a_clear_s    = !output_a_stb || output_a_ack;
  assign b_clear_s    = !output_b_stb || output_b_ack;
  assign last_s       = (index_r == (count_r - CNT_ONE));
  assign next_index_s = index_r + CNT_ONE;

  // Job sequencer; every output is a register updated on the edge that enters its state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= IDLE;
      count_r      <= CNT_ZERO;
      index_r      <= CNT_ZERO;
      op_base_r    <= ADDR_ZERO;
      res_base_r   <= ADDR_ZERO;
      busy         <= 1'b0;
      done         <= 1'b0;
      nan_count    <= CNT_ZERO;
      op_rd_en     <= 1'b0;
      op_addr      <= ADDR_ZERO;
      res_wr_en    <= 1'b0;
      res_addr     <= ADDR_ZERO;
      res_wr_data  <= 32'h00000000;
      output_a     <= 32'h00000000;
      output_a_stb <= 1'b0;
      output_b     <= 32'h00000000;
      output_b_stb <= 1'b0;
      input_z_ack  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            count_r    <= count;
            op_base_r  <= op_base;
            res_base_r <= res_base;
            index_r    <= CNT_ZERO;
            nan_count  <= CNT_ZERO;
            busy       <= 1'b1;
            if (count == CNT_ZERO) begin
              state_r <= DONE;
            end else begin
              op_rd_en <= 1'b1;
              op_addr  <= op_base;
              state_r  <= FETCH;
            end
          end
        end
        FETCH: begin
          op_rd_en <= 1'b0;
          state_r  <= LOAD;
        end
        LOAD: begin
          output_a     <= op_rd_data[63:32];
          output_b     <= op_rd_data[31:0];
          output_a_stb <= 1'b1;
          output_b_stb <= 1'b1;
          state_r      <= SEND;
        end
        SEND: begin
          if (output_a_stb && output_a_ack) begin
            output_a_stb <= 1'b0;
          end
          if (output_b_stb && output_b_ack) begin
            output_b_stb <= 1'b0;
          end
          if (a_clear_s && b_clear_s) begin
            input_z_ack <= 1'b1;
            state_r     <= WAIT_Z;
          end
        end
        WAIT_Z: begin
          if (input_z_stb) begin
            input_z_ack <= 1'b0;
            res_wr_en   <= 1'b1;
            res_addr    <= res_base_r + index_r[ADDR_W-1:0];
            res_wr_data <= input_z;
            if (is_nan(input_z) && (nan_count != NAN_MAX)) begin
              nan_count <= nan_count + CNT_ONE;
            end
            state_r <= WRITE;
          end
        end
        WRITE: begin
          res_wr_en <= 1'b0;
          if (last_s) begin
            state_r <= DONE;
          end else begin
            index_r  <= next_index_s;
            op_rd_en <= 1'b1;
            op_addr  <= op_base_r + next_index_s[ADDR_W-1:0];
            state_r  <= FETCH;
          end
        end
        DONE: begin
          done    <= 1'b1;
          busy    <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          busy         <= 1'b0;
          op_rd_en     <= 1'b0;
          res_wr_en    <= 1'b0;
          output_a_stb <= 1'b0;
          output_b_stb <= 1'b0;
          input_z_ack  <= 1'b0;
          state_r      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp_op_driver.sv
// Directed bench for fp_op_driver: operand/result RAM models, a configurable
// unit responder, a table of jobs and a few hand-written timing sequences.
module tb_fp_op_driver;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [8:0]  count = 9'd0;
  logic [7:0]  op_base = 8'd0;
  logic [7:0]  res_base = 8'd0;
  logic        busy, done, op_rd_en, res_wr_en;
  logic [8:0]  nan_count;
  logic [7:0]  op_addr, res_addr;
  logic [63:0] op_rd_data;
  logic [31:0] res_wr_data, output_a, output_b, input_z;
  logic        output_a_stb, output_b_stb, input_z_stb, input_z_ack;

  logic        a_ack, b_ack, z_stb_r, a_have, b_have;
  logic [31:0] z_val, got_a, got_b;
  int          a_wait, b_wait, z_wait;
  int          a_dly = 0, b_dly = 0, z_dly = 0;
  logic        stray_stb = 1'b0;
  logic [31:0] stray_z = 32'h0;

  logic [63:0] op_mem [256];
  logic [31:0] res_mem [256];
  logic        clr_mon = 1'b0;
  int          wr_cnt, rd_cnt, done_cnt, stb_cyc, a_xfer, b_xfer, stab_err;
  logic        a_pend, b_pend;
  logic [31:0] a_pend_v, b_pend_v;

  int total = 0;
  int bad = 0;

  assign input_z_stb = z_stb_r | stray_stb;
  assign input_z     = stray_stb ? stray_z : z_val;

  always #5 clk = ~clk;

  fp_op_driver #(.ADDR_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .count(count), .op_base(op_base),
    .res_base(res_base), .busy(busy), .done(done), .nan_count(nan_count),
    .op_rd_en(op_rd_en), .op_addr(op_addr), .op_rd_data(op_rd_data),
    .res_wr_en(res_wr_en), .res_addr(res_addr), .res_wr_data(res_wr_data),
    .output_a(output_a), .output_a_stb(output_a_stb), .output_a_ack(a_ack),
    .output_b(output_b), .output_b_stb(output_b_stb), .output_b_ack(b_ack),
    .input_z(input_z), .input_z_stb(input_z_stb), .input_z_ack(input_z_ack)
  );

  // Stand-in for the arithmetic unit: known FP sums, integer add otherwise.
  function automatic logic [31:0] unit_fn(input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      64'h3F800000_40000000: return 32'h40400000;
      64'h3F800000_3F800000: return 32'h40000000;
      64'h40000000_40000000: return 32'h40800000;
      64'h7F800000_FF800000: return 32'hFFC00000;
      64'h7F800000_3F800000: return 32'h7F800000;
      64'h7FC00000_3F800000: return 32'h7FC00000;
      default:               return a + b;
    endcase
  endfunction

  always @(posedge clk) begin
    if (op_rd_en) op_rd_data <= op_mem[op_addr];
  end

  // Unit responder: programmable ack delays per operand and result latency.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_ack <= 1'b0; b_ack <= 1'b0; z_stb_r <= 1'b0; z_val <= 32'h0;
      got_a <= 32'h0; got_b <= 32'h0; a_have <= 1'b0; b_have <= 1'b0;
      a_wait <= 0; b_wait <= 0; z_wait <= 0;
    end else begin
      if (output_a_stb && a_ack) begin
        a_have <= 1'b1; got_a <= output_a; a_ack <= (a_dly == 0); a_wait <= 0;
      end else if (output_a_stb) begin
        a_wait <= a_wait + 1; a_ack <= (a_wait + 1 >= a_dly);
      end else begin
        a_wait <= 0; a_ack <= (a_dly == 0);
      end
      if (output_b_stb && b_ack) begin
        b_have <= 1'b1; got_b <= output_b; b_ack <= (b_dly == 0); b_wait <= 0;
      end else if (output_b_stb) begin
        b_wait <= b_wait + 1; b_ack <= (b_wait + 1 >= b_dly);
      end else begin
        b_wait <= 0; b_ack <= (b_dly == 0);
      end
      if (z_stb_r && input_z_ack) begin
        z_stb_r <= 1'b0; a_have <= 1'b0; b_have <= 1'b0; z_wait <= 0;
      end else if (a_have && b_have && !z_stb_r) begin
        if (z_wait >= z_dly) begin
          z_stb_r <= 1'b1; z_val <= unit_fn(got_a, got_b);
        end else begin
          z_wait <= z_wait + 1;
        end
      end
    end
  end

  // Activity counters, result RAM and operand-stability tracking.
  always @(posedge clk) begin
    if (clr_mon) begin
      wr_cnt <= 0; rd_cnt <= 0; done_cnt <= 0; stb_cyc <= 0;
      a_xfer <= 0; b_xfer <= 0; stab_err <= 0; a_pend <= 1'b0; b_pend <= 1'b0;
      for (int i = 0; i < 256; i++) res_mem[i] <= 32'hDEADBEEF;
    end else begin
      if (res_wr_en) begin
        res_mem[res_addr] <= res_wr_data;
        wr_cnt <= wr_cnt + 1;
      end
      if (op_rd_en) rd_cnt <= rd_cnt + 1;
      if (done) done_cnt <= done_cnt + 1;
      if (output_a_stb || output_b_stb) stb_cyc <= stb_cyc + 1;
      if (output_a_stb && a_ack) a_xfer <= a_xfer + 1;
      if (output_b_stb && b_ack) b_xfer <= b_xfer + 1;
      stab_err <= stab_err + int'(a_pend && (!output_a_stb || output_a != a_pend_v))
                           + int'(b_pend && (!output_b_stb || output_b != b_pend_v));
      a_pend <= output_a_stb && !a_ack; a_pend_v <= output_a;
      b_pend <= output_b_stb && !b_ack; b_pend_v <= output_b;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] z;
  } pair_t;

  typedef struct {
    int         n;
    int         first;
    logic [7:0] ob;
    logic [7:0] rb;
    int         ad;
    int         bd;
    int         zd;
    int         exp_nan;
    bit         restart;
    bit         gen;
  } job_t;

  pair_t vec [6];
  job_t  jobs [5];

  task automatic clear_mon();
    @(negedge clk); clr_mon = 1'b1;
    @(negedge clk); clr_mon = 1'b0;
  endtask

  task automatic run_job(input int j);
    job_t       jb;
    logic [7:0] ad;
    logic [31:0] ez;
    bit         seen;
    jb = jobs[j];
    for (int i = 0; i < jb.n; i++) begin
      ad = jb.ob + 8'(i);
      op_mem[ad] = jb.gen ? {32'(i), 32'h00000100} : {vec[jb.first+i].a, vec[jb.first+i].b};
    end
    a_dly = jb.ad; b_dly = jb.bd; z_dly = jb.zd;
    clear_mon();
    start = 1'b1; count = 9'(jb.n); op_base = jb.ob; res_base = jb.rb;
    @(negedge clk);
    start = 1'b0; count = 9'd5; op_base = 8'h33; res_base = 8'h44;
    if (jb.restart) begin
      repeat (4) @(negedge clk);
      start = 1'b1; count = 9'd1; op_base = 8'h00; res_base = 8'h00;
      @(negedge clk);
      start = 1'b0;
    end
    seen = 1'b0;
    for (int c = 0; c < 4000 && !seen; c++) begin
      if (done) seen = 1'b1;
      else @(negedge clk);
    end
    chk($sformatf("j%0d_done_seen", j), 64'(seen), 64'd1);
    repeat (3) @(negedge clk);
    chk($sformatf("j%0d_done_cnt", j), 64'(done_cnt), 64'd1);
    chk($sformatf("j%0d_busy", j), 64'(busy), 64'd0);
    chk($sformatf("j%0d_rd_cnt", j), 64'(rd_cnt), 64'(jb.n));
    chk($sformatf("j%0d_wr_cnt", j), 64'(wr_cnt), 64'(jb.n));
    chk($sformatf("j%0d_a_xfer", j), 64'(a_xfer), 64'(jb.n));
    chk($sformatf("j%0d_b_xfer", j), 64'(b_xfer), 64'(jb.n));
    chk($sformatf("j%0d_stable", j), 64'(stab_err), 64'd0);
    chk($sformatf("j%0d_nan", j), 64'(nan_count), 64'(jb.exp_nan));
    if (jb.n == 0) chk($sformatf("j%0d_stb_cyc", j), 64'(stb_cyc), 64'd0);
    for (int i = 0; i < jb.n; i++) begin
      ad = jb.rb + 8'(i);
      ez = jb.gen ? 32'(i) + 32'h00000100 : vec[jb.first+i].z;
      chk($sformatf("j%0d_res%0d@%h", j, i, ad), 64'(res_mem[ad]), 64'(ez));
    end
  endtask

  initial begin
    bit seen;
    vec[0] = '{32'h3F800000, 32'h40000000, 32'h40400000};
    vec[1] = '{32'h3F800000, 32'h3F800000, 32'h40000000};
    vec[2] = '{32'h40000000, 32'h40000000, 32'h40800000};
    vec[3] = '{32'h7F800000, 32'hFF800000, 32'hFFC00000};
    vec[4] = '{32'h7F800000, 32'h3F800000, 32'h7F800000};
    vec[5] = '{32'h7FC00000, 32'h3F800000, 32'h7FC00000};
    //          n    first ob     rb     ad bd zd nan restart gen
    jobs[0] = '{1,   0,    8'h05, 8'h10, 0, 0, 0, 0,  1'b0,  1'b0};
    jobs[1] = '{3,   1,    8'hFE, 8'hFF, 0, 0, 0, 1,  1'b1,  1'b0};
    jobs[2] = '{0,   0,    8'h00, 8'h00, 0, 0, 0, 0,  1'b0,  1'b0};
    jobs[3] = '{256, 0,    8'h00, 8'h37, 0, 0, 0, 0,  1'b0,  1'b1};
    jobs[4] = '{2,   4,    8'h40, 8'h80, 7, 1, 4, 1,  1'b0,  1'b0};

    repeat (3) @(negedge clk);
    chk("reset_outputs", 64'({busy, done, nan_count, op_rd_en, res_wr_en, output_a_stb,
                              output_b_stb, input_z_ack}), 64'd0);
    rst = 1'b1;

    // Reset while operand a is held in SEND with no ack.
    op_mem[8'h05] = {32'h3F800000, 32'h40000000};
    a_dly = 20;
    @(negedge clk);
    start = 1'b1; count = 9'd1; op_base = 8'h05; res_base = 8'h10;
    @(negedge clk);
    start = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      if (output_a_stb) seen = 1'b1;
      else @(negedge clk);
    end
    chk("rst_mid_send_reached", 64'(seen), 64'd1);
    #2 rst = 1'b0;
    #1;
    chk("rst_async_ctrl", 64'({busy, done, op_rd_en, res_wr_en, output_a_stb, output_b_stb,
                               input_z_ack, nan_count}), 64'd0);
    chk("rst_async_data", {output_a, output_b}, 64'd0);
    a_dly = 0;
    @(negedge clk);
    rst = 1'b1;

    for (int j = 0; j < 5; j++) run_job(j);

    // Stray result stb while ack is low must not be consumed.
    clear_mon();
    stray_z = 32'h7FC00000;
    stray_stb = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (input_z_ack) seen = 1'b1;
    end
    stray_stb = 1'b0;
    @(negedge clk);
    chk("stray_z_ack", 64'(seen), 64'd0);
    chk("stray_z_wr", 64'(wr_cnt), 64'd0);
    chk("stray_nan_hold", 64'(nan_count), 64'd1);

    // count==0: done exactly two cycles after start.
    start = 1'b1; count = 9'd0;
    @(negedge clk);
    start = 1'b0;
    chk("c0_cyc1_busy", 64'(busy), 64'd1);
    chk("c0_cyc1_done", 64'(done), 64'd0);
    chk("c0_cyc1_nan_clr", 64'(nan_count), 64'd0);
    @(negedge clk);
    chk("c0_cyc2_done", 64'(done), 64'd1);
    chk("c0_cyc2_busy", 64'(busy), 64'd0);
    @(negedge clk);
    chk("c0_cyc3_done", 64'(done), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fp_op_driver.md
Name: fp_op_driver

Overview:
- Initiator for the single-precision arithmetic units' stb/ack operand/result protocol: the driving end of input_a/input_b/output_z.
- Fetches operand pairs from an operand RAM and presents them to one unit (e.g. adder).
- Collects each result and writes it to a result RAM.
- Batch job launched by start/count; used by collision-detection datapaths to stream vector arithmetic.

Parameters:
ADDR_W, 8, address width of operand and result RAMs; addresses wrap modulo 2^ADDR_W.

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
start  in  1  one-cycle job request; honoured only in IDLE
count  in  ADDR_W+1  number of operand pairs, 0..2^ADDR_W; latched on start
op_base  in  ADDR_W  first operand address; latched on start
res_base  in  ADDR_W  first result address; latched on start
busy  out  1  high from cycle after accepted start until DONE exits
done  out  1  one-cycle pulse at job end
nan_count  out  ADDR_W+1  results with exponent 255 and nonzero mantissa in last job
op_rd_en  out  1  operand RAM read strobe
op_addr  out  ADDR_W  operand RAM address
op_rd_data  in  64  {a[63:32], b[31:0]}; valid the cycle after op_rd_en
res_wr_en  out  1  result RAM write strobe
res_addr  out  ADDR_W  result RAM address
res_wr_data  out  32  result word
output_a  out  32  operand a to unit
output_a_stb  out  1  operand a valid
output_a_ack  in  1  unit ready for a
output_b  out  32  operand b to unit
output_b_stb  out  1  operand b valid
output_b_ack  in  1  unit ready for b
input_z  in  32  result from unit
input_z_stb  in  1  result valid
input_z_ack  out  1  driver ready for result

Behaviour:
- Reset (rst low, asynchronous): state IDLE; all outputs 0, including nan_count and index. Unit must be reset in the same event; no handshake survives reset.
- Transfer rule: a word transfers on a rising edge where stb and ack are both high. Sender holds data and stb stable until that edge; ack may rise before or after stb.
- All outputs registered.
- States:
  - IDLE: on start, latch count/op_base/res_base; clear index and nan_count; busy<=1. Go to DONE if count==0, else FETCH.
  - FETCH: op_rd_en=1 for one cycle, op_addr=op_base+index; go to LOAD.
  - LOAD: capture op_rd_data into output_a/output_b; assert output_a_stb and output_b_stb; go to SEND.
  - SEND: each stb drops independently on the edge its own transfer occurs. When both have transferred (either order, or same edge), go to WAIT_Z with input_z_ack=1.
  - WAIT_Z: hold input_z_ack=1. On the edge input_z_stb is high, capture input_z, drop input_z_ack, increment nan_count if NaN; go to WRITE.
  - WRITE: res_wr_en=1 for one cycle, res_addr=res_base+index, res_wr_data=captured z. If index==count-1 go to DONE, else index+1 and FETCH.
  - DONE: done=1 for one cycle; busy<=0; go to IDLE.
- Latency: per pair 5 cycles of driver overhead plus unit latency and handshake waits. count==0 gives done exactly 2 cycles after start, with no RAM or unit activity.
- Input handling:
  - start outside IDLE is ignored.
  - count, op_base and res_base changes during a job have no effect.
- Address arithmetic: op_base+index and res_base+index wrap modulo 2^ADDR_W. count=2^ADDR_W processes every address once.
- Protocol checks:
  - output_a_stb and output_b_stb are never high outside SEND.
  - input_z_ack is never high outside WAIT_Z.
  - A z arriving with stb while ack is low is not consumed.
- nan_count saturates at 2^ADDR_W; it holds its value after done until the next accepted start.

Test Plan:
- Reset mid-SEND (output_a_stb high): drop rst → all outputs 0 asynchronously, state IDLE; next start runs a clean job.
- count=1, op_base=5, RAM[5]={0x3F800000,0x40000000}, adder attached → res_wr_data=0x40400000 at res_addr=res_base; done pulses once; nan_count=0.
- count=3, op_base=0xFE, res_base=0xFF, pairs 1+1, 2+2, inf+(-inf) → writes 0x40000000@0xFF, 0x40800000@0x00, 0xFFC00000@0x01; nan_count=1.
- count=0 → done 2 cycles after start; op_rd_en and res_wr_en never asserted; no stb asserted.
- Bench responder delays output_a_ack 7 cycles, raises output_b_ack before output_a_ack, holds input_z_stb 4 cycles before ack → each operand transfers exactly once, data stable while stb high; result captured on first stb&&ack edge.
- start pulsed again while busy with different count → ignored; original job completes with the original count.
